// File: rtl/am_operand_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | am_operand_unit_if : instruction, memory-read and write-back bundle      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface am_operand_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        opcode;
  logic [REG_AW-1:0] op1_regaddr;
  logic [DATA_W-1:0] op2_data;
  logic [DATA_W-1:0] imm;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [REG_AW-1:0] wb_regaddr;
  logic              err_illegal;
  logic              err_timeout;

  modport master (
    output in_valid, opcode, op1_regaddr, op2_data, imm, mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_addr, wb_valid, wb_data, wb_regaddr,
           err_illegal, err_timeout
  );

  modport slave (
    input  in_valid, opcode, op1_regaddr, op2_data, imm, mem_ack, mem_rdata,
    output in_ready, mem_req, mem_addr, wb_valid, wb_data, wb_regaddr,
           err_illegal, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/am_operand_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | am_operand_unit : addressing-mode resolver and operand fetch             |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module am_operand_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int REG_AW   = 3,
  parameter int ACC_ADDR = 0,
  parameter int TIMEOUT  = 15
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  am_operand_unit_if.slave   bus
);

  localparam logic [3:0]        OP_MOV  = 4'b1011;
  localparam logic [3:0]        OP_MVI  = 4'b1100;
  localparam logic [3:0]        OP_LDA  = 4'b1101;
  localparam logic [3:0]        OP_LDR  = 4'b1110;
  localparam logic [7:0]        TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [REG_AW-1:0] ACC_REG = REG_AW'(ACC_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [REG_AW-1:0] wbr_q, wbr_d;
  logic [DATA_W-1:0] wbd_q, wbd_d;
  logic              ill_q, ill_d;
  logic              tmo_q, tmo_d;
  logic [ADDR_W-1:0] lda_addr;
  logic [ADDR_W-1:0] ldr_addr;

  if (ADDR_W <= DATA_W) begin : g_addr_trunc
    assign lda_addr = bus.imm[ADDR_W-1:0];
    assign ldr_addr = bus.op2_data[ADDR_W-1:0];
  end else begin : g_addr_zext
    assign lda_addr = {{(ADDR_W-DATA_W){1'b0}}, bus.imm};
    assign ldr_addr = {{(ADDR_W-DATA_W){1'b0}}, bus.op2_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt_q  <= '0;
      addr_q <= '0;
      dest_q <= '0;
      wbr_q  <= '0;
      wbd_q  <= '0;
      ill_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      state  <= next_state;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      dest_q <= dest_d;
      wbr_q  <= wbr_d;
      wbd_q  <= wbd_d;
      ill_q  <= ill_d;
      tmo_q  <= tmo_d;
    end
  end

  // Write-back registers only change on entry to WB so they hold between strobes.
  always_comb begin
    next_state = state;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    dest_d     = dest_q;
    wbr_d      = wbr_q;
    wbd_d      = wbd_q;
    ill_d      = 1'b0;
    tmo_d      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          case (bus.opcode)
            OP_MOV: begin
              wbd_d      = bus.op2_data;
              wbr_d      = bus.op1_regaddr;
              next_state = WB;
            end
            OP_MVI: begin
              wbd_d      = bus.imm;
              wbr_d      = bus.op1_regaddr;
              next_state = WB;
            end
            OP_LDA: begin
              addr_d     = lda_addr;
              dest_d     = ACC_REG;
              cnt_d      = '0;
              next_state = MEM;
            end
            OP_LDR: begin
              addr_d     = ldr_addr;
              dest_d     = bus.op1_regaddr;
              cnt_d      = '0;
              next_state = MEM;
            end
            default: ill_d = 1'b1;
          endcase
        end
      end
      MEM: begin
        // An ack on the final permitted cycle still completes the load.
        if (bus.mem_ack) begin
          wbd_d      = bus.mem_rdata;
          wbr_d      = dest_q;
          cnt_d      = '0;
          next_state = WB;
        end else if (cnt_q == TO_LAST) begin
          tmo_d      = 1'b1;
          cnt_d      = '0;
          next_state = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WB:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.mem_req     = (state == MEM);
  assign bus.mem_addr    = addr_q;
  assign bus.wb_valid    = (state == WB);
  assign bus.wb_data     = wbd_q;
  assign bus.wb_regaddr  = wbr_q;
  assign bus.err_illegal = ill_q;
  assign bus.err_timeout = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_am_operand_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_am_operand_unit : directed self-checking bench for am_operand_unit    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_am_operand_unit;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   fails  = 0;

  am_operand_unit_if #(.DATA_W(16), .ADDR_W(16), .REG_AW(3)) bus ();

  am_operand_unit #(
    .DATA_W(16), .ADDR_W(16), .REG_AW(3), .ACC_ADDR(0), .TIMEOUT(15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] r1,
                       input logic [15:0] d2, input logic [15:0] im);
    bus.in_valid    = 1'b1;
    bus.opcode      = op;
    bus.op1_regaddr = r1;
    bus.op2_data    = d2;
    bus.imm         = im;
  endtask

  task automatic test_reset();
    reset_n         = 1'b0;
    bus.in_valid    = 1'b0;
    bus.opcode      = 4'b0;
    bus.op1_regaddr = 3'd0;
    bus.op2_data    = 16'h0;
    bus.imm         = 16'h0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 16'h0;
    #12;
    checks++;
    if ({bus.in_ready, bus.mem_req, bus.wb_valid, bus.err_illegal, bus.err_timeout} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 10000",
               {bus.in_ready, bus.mem_req, bus.wb_valid, bus.err_illegal, bus.err_timeout});
    end
    checks++;
    if ({bus.wb_data, bus.wb_regaddr, bus.mem_addr} !== 35'd0) begin
      fails++;
      $display("FAIL reset_data: wb_data=%h wb_regaddr=%0d mem_addr=%h expected all 0",
               bus.wb_data, bus.wb_regaddr, bus.mem_addr);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_mov();
    drive(4'b1011, 3'd5, 16'hBEEF, 16'h0000);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.wb_valid, bus.wb_regaddr, bus.wb_data, bus.mem_req, bus.in_ready} !== {1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL mov_wb: valid=%b reg=%0d data=%h mem_req=%b in_ready=%b expected 1 5 beef 0 0",
               bus.wb_valid, bus.wb_regaddr, bus.wb_data, bus.mem_req, bus.in_ready);
    end
    step();
    checks++;
    if ({bus.wb_valid, bus.in_ready, bus.wb_data} !== {1'b0, 1'b1, 16'hBEEF}) begin
      fails++;
      $display("FAIL mov_after: valid=%b in_ready=%b data=%h expected 0 1 beef",
               bus.wb_valid, bus.in_ready, bus.wb_data);
    end
  endtask

  task automatic test_mvi();
    drive(4'b1100, 3'd2, 16'h0000, 16'h1234);
    step();
    bus.in_valid    = 1'b0;
    bus.opcode      = 4'b1011;
    bus.op1_regaddr = 3'd6;
    bus.op2_data    = 16'h7777;
    bus.imm         = 16'hFFFF;
    #2;
    checks++;
    if ({bus.wb_valid, bus.wb_regaddr, bus.wb_data} !== {1'b1, 3'd2, 16'h1234}) begin
      fails++;
      $display("FAIL mvi_wb: valid=%b reg=%0d data=%h expected 1 2 1234",
               bus.wb_valid, bus.wb_regaddr, bus.wb_data);
    end
    step();
    checks++;
    if ({bus.wb_valid, bus.in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL mvi_single_strobe: valid=%b in_ready=%b expected 0 1", bus.wb_valid, bus.in_ready);
    end
  endtask

  task automatic test_lda();
    int bad = 0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    step();
    bus.mem_ack = 1'b0;
    checks++;
    if ({bus.wb_valid, bus.mem_req, bus.in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL idle_ack_ignored: valid=%b mem_req=%b in_ready=%b expected 0 0 1",
               bus.wb_valid, bus.mem_req, bus.in_ready);
    end
    drive(4'b1101, 3'd3, 16'h0999, 16'h0040);
    step();
    bus.in_valid = 1'b0;
    bus.imm      = 16'h0;
    for (int c = 1; c <= 3; c++) begin
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0040 || bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b0)
        bad++;
      if (c == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hA5A5;
      end
      step();
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL lda_mem_phase: %0d bad cycles expected 0", bad);
    end
    checks++;
    if ({bus.wb_valid, bus.wb_regaddr, bus.wb_data, bus.mem_req} !== {1'b1, 3'd0, 16'hA5A5, 1'b0}) begin
      fails++;
      $display("FAIL lda_wb: valid=%b reg=%0d data=%h mem_req=%b expected 1 0 a5a5 0",
               bus.wb_valid, bus.wb_regaddr, bus.wb_data, bus.mem_req);
    end
    step();
    checks++;
    if ({bus.wb_valid, bus.in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL lda_after: valid=%b in_ready=%b expected 0 1", bus.wb_valid, bus.in_ready);
    end
  endtask

  task automatic test_ldr_timeout();
    int req_cycles = 0;
    int wb_seen    = 0;
    drive(4'b1110, 3'd7, 16'h0100, 16'h0000);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mem_addr !== 16'h0100) begin
      fails++;
      $display("FAIL ldr_addr: got %h expected 0100", bus.mem_addr);
    end
    for (int c = 1; c <= 15; c++) begin
      if (bus.mem_req === 1'b1) req_cycles++;
      if (bus.wb_valid !== 1'b0 || bus.err_timeout !== 1'b0) wb_seen++;
      step();
    end
    checks++;
    if (req_cycles != 15 || wb_seen != 0) begin
      fails++;
      $display("FAIL ldr_req_cycles: req=%0d early_events=%0d expected 15 0", req_cycles, wb_seen);
    end
    checks++;
    if ({bus.mem_req, bus.err_timeout, bus.wb_valid, bus.in_ready} !== 4'b0101) begin
      fails++;
      $display("FAIL ldr_timeout: mem_req=%b err_timeout=%b wb_valid=%b in_ready=%b expected 0 1 0 1",
               bus.mem_req, bus.err_timeout, bus.wb_valid, bus.in_ready);
    end
    step();
    checks++;
    if ({bus.err_timeout, bus.wb_valid, bus.in_ready} !== 3'b001) begin
      fails++;
      $display("FAIL ldr_timeout_pulse: err_timeout=%b wb_valid=%b in_ready=%b expected 0 0 1",
               bus.err_timeout, bus.wb_valid, bus.in_ready);
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  ops [2] = '{4'b0000, 4'b1111};
    logic [15:0] vals[2] = '{16'h0101, 16'h0202};
    for (int k = 0; k < 2; k++) begin
      drive(ops[k], 3'd4, 16'h3333, 16'h4444);
      step();
      checks++;
      if ({bus.err_illegal, bus.in_ready, bus.wb_valid, bus.mem_req} !== 4'b1100) begin
        fails++;
        $display("FAIL illegal_%0d: err=%b in_ready=%b wb_valid=%b mem_req=%b expected 1 1 0 0",
                 k, bus.err_illegal, bus.in_ready, bus.wb_valid, bus.mem_req);
      end
      drive(4'b1011, 3'd1, vals[k], 16'h0000);
      step();
      bus.in_valid = 1'b0;
      checks++;
      if ({bus.err_illegal, bus.wb_valid, bus.wb_regaddr, bus.wb_data} !== {1'b0, 1'b1, 3'd1, vals[k]}) begin
        fails++;
        $display("FAIL illegal_then_mov_%0d: err=%b valid=%b reg=%0d data=%h expected 0 1 1 %h",
                 k, bus.err_illegal, bus.wb_valid, bus.wb_regaddr, bus.wb_data, vals[k]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_mem();
    int bad = 0;
    drive(4'b1110, 3'd4, 16'h0200, 16'h0000);
    step();
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.mem_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_mem_req: got %b expected 1", bus.mem_req);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, bus.in_ready, bus.wb_valid, bus.err_illegal, bus.err_timeout} !== 5'b01000
        || {bus.wb_data, bus.wb_regaddr, bus.mem_addr} !== 35'd0) begin
      fails++;
      $display("FAIL rst_async: mem_req=%b in_ready=%b wb_valid=%b errs=%b%b wb_data=%h mem_addr=%h expected 0 1 0 00 0 0",
               bus.mem_req, bus.in_ready, bus.wb_valid, bus.err_illegal, bus.err_timeout,
               bus.wb_data, bus.mem_addr);
    end
    step();
    reset_n       = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.wb_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.in_ready !== 1'b1 || bus.err_timeout !== 1'b0)
        bad++;
    end
    bus.mem_ack = 1'b0;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rst_ack_ignored: %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_mov();
    test_mvi();
    test_lda();
    test_ldr_timeout();
    test_illegal();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/am_operand_unit.md
Name: am_operand_unit

Overview:
- Sequential, parametrised addressing-mode and operand-fetch unit.
- Sits between instruction decode and the register file. It accepts one decoded instruction at a time, resolves the operand by addressing mode, and issues exactly one register-file write-back per legal instruction.
- Modes:
  - Register move (MOV) and immediate (MVI) complete in one cycle.
  - Direct load to the accumulator (LDA) and register-indirect load (LDR) run a memory read handshake with a timeout.

Parameters:
- DATA_W, 16, width of data, immediate and memory read data.
- ADDR_W, 16, memory address width; immediate/op2 data are truncated or zero-extended to ADDR_W.
- REG_AW, 3, register address width.
- ACC_ADDR, 0, register index of the accumulator (LDA destination).
- TIMEOUT, 15, maximum cycles mem_req is held without mem_ack before abort; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  unit can accept an instruction (high only in IDLE)
- opcode  in  4  1011 MOV, 1100 MVI, 1101 LDA, 1110 LDR, others illegal
- op1_regaddr  in  REG_AW  destination register
- op2_data  in  DATA_W  source register contents (MOV data, LDR address)
- imm  in  DATA_W  second instruction word (MVI data, LDA address)
- mem_req  out  1  memory read request, held until ack or timeout
- mem_addr  out  ADDR_W  read address, stable while mem_req high
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  DATA_W  read data
- wb_valid  out  1  one-cycle write-back strobe
- wb_data  out  DATA_W  write-back data
- wb_regaddr  out  REG_AW  write-back register
- err_illegal  out  1  one-cycle pulse on illegal opcode
- err_timeout  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except in_ready=1.
  - The timeout counter clears.
  - Reset mid-transaction drops mem_req immediately; no write-back and no error pulse are produced.
- Acceptance: an instruction is accepted on a rising edge where in_valid && in_ready. opcode, op1_regaddr, op2_data and imm are registered at acceptance; later input changes are ignored.
- States: IDLE, MEM, WB.
  - IDLE, accept MOV: next WB with wb_data=op2_data, wb_regaddr=op1_regaddr.
  - IDLE, accept MVI: next WB with wb_data=imm, wb_regaddr=op1_regaddr.
  - IDLE, accept LDA: next MEM with mem_addr=imm[ADDR_W-1:0] (zero-extended if ADDR_W>DATA_W), destination ACC_ADDR.
  - IDLE, accept LDR: next MEM with mem_addr=op2_data, destination op1_regaddr.
  - IDLE, accept illegal opcode: err_illegal=1 for the following cycle; stay in IDLE (in_ready stays 1). No write-back and no memory access.
  - MEM:
    - mem_req=1 from the cycle after acceptance.
    - On a rising edge with mem_ack=1, capture mem_rdata, then go to WB.
    - The counter increments each MEM cycle without ack. If no ack arrives by the TIMEOUT-th MEM cycle, abort: mem_req=0 and err_timeout=1 for one cycle, then IDLE with no write-back.
    - An ack in the same cycle the counter reaches TIMEOUT counts as success; ack wins.
  - WB: wb_valid=1 for exactly one cycle with wb_data/wb_regaddr stable; next IDLE.
- wb_data and wb_regaddr hold their last values when wb_valid=0. Consumers use only the strobe.
- Latency (acceptance edge = cycle 0):
  - MOV/MVI: wb_valid in cycle 1; next accept possible at the edge ending cycle 2.
  - Loads: mem_req from cycle 1; wb_valid in the cycle after the ack edge.
- mem_ack while not in MEM is ignored.
- Accepting is impossible outside IDLE, so at most one instruction is in flight.

Test Plan:
- MOV opcode=1011, op1=5, op2_data=16'hBEEF -> wb_valid cycle 1, wb_regaddr=5, wb_data=16'hBEEF; no mem_req.
- MVI opcode=1100, op1=2, imm=16'h1234; inputs changed in cycle 1 -> wb_data=16'h1234, wb_regaddr=2 (registered values).
- LDA imm=16'h0040, mem_ack after 3 cycles with rdata=16'hA5A5 -> mem_addr=0x0040 held 3 cycles; wb_regaddr=0, wb_data=16'hA5A5, one strobe.
- LDR op1=7, op2_data=16'h0100, never ack, TIMEOUT=15 -> mem_req high 15 cycles, then err_timeout pulse, no wb_valid, in_ready returns 1.
- Opcode 0000 and 1111 -> err_illegal one-cycle pulse each, no wb_valid, unit accepts a MOV on the very next edge.
- reset_n pulled low mid-MEM, then mem_ack asserted after release -> mem_req drops asynchronously; ack ignored; no wb_valid; all outputs 0, in_ready=1.
